// File: rtl/usb_cmd_decoder_if.sv
// Command word and SPI handshake bundle between the USB reader, the decoder and the SPI driver.
// Word handshake: a word transfers on a posedge where i_word_valid and o_cmd_ready are both 1;
// a valid word seen while o_cmd_ready is 0 is lost, and the decoder counts it as an error.
interface usb_cmd_decoder_if;
  logic [31:0] i_word;
  logic        i_word_valid;
  logic        o_cmd_ready;
  logic        o_spi_start;
  logic [39:0] o_spi_data;
  logic        i_spi_busy;

  modport master (
    output i_word, i_word_valid, i_spi_busy,
    input  o_cmd_ready, o_spi_start, o_spi_data
  );

  modport slave (
    input  i_word, i_word_valid, i_spi_busy,
    output o_cmd_ready, o_spi_start, o_spi_data
  );
endinterface

// File: rtl/usb_cmd_decoder.sv
// Decodes USB command words into SPI transfers and sweep register writes.
// The decoder is armed by a magic word and counts rejected or lost words and SPI timeouts.
module usb_cmd_decoder #(
    parameter logic [31:0] MAGIC        = 32'hF00DBABE,
    parameter logic [7:0]  SPI_PREFIX   = 8'h02,
    parameter int          BUSY_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    usb_cmd_decoder_if.slave   bus,
    output logic               o_armed,
    output logic [31:0]        o_sweep_diff,
    output logic [31:0]        o_sweep_start,
    output logic [31:0]        o_sweep_stop,
    output logic               o_sweep_update,
    output logic [7:0]         o_err_count,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        WAIT_MAGIC    = 3'd0,
        ARMED         = 3'd1,
        SPI_START     = 3'd2,
        SPI_WAIT_BUSY = 3'd3,
        SPI_WAIT_DONE = 3'd4
    } state_t;

    localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT - 1);

    state_t        state, state_next;
    logic [TW-1:0] timer;
    logic          accept;
    logic [1:0]    op;
    logic [5:0]    sel;
    logic          spi_load;
    logic          sweep_wr;
    logic          sweep_wr_q;
    logic          err_any;
    logic [6:0]    unused_word_bits;

    assign op               = bus.i_word[31:30];
    assign sel              = bus.i_word[29:24];
    assign unused_word_bits = bus.i_word[22:16];

    assign bus.o_cmd_ready = (state == WAIT_MAGIC) || (state == ARMED);
    assign bus.o_spi_start = (state == SPI_START);
    assign o_armed         = (state != WAIT_MAGIC);
    assign dbg_state       = state;
    assign accept          = bus.i_word_valid && bus.o_cmd_ready;

    function automatic logic [31:0] merge_half(input logic [31:0] old, input logic upper,
                                               input logic [15:0] data);
        merge_half = upper ? {data, old[15:0]} : {old[31:16], data};
    endfunction

    always_comb begin
        state_next = state;
        spi_load   = 1'b0;
        sweep_wr   = 1'b0;
        // Any drop, bad selector or timeout in the same cycle counts as a single error.
        err_any    = bus.i_word_valid && !bus.o_cmd_ready;
        unique case (state)
            WAIT_MAGIC: begin
                if (accept && bus.i_word == MAGIC) state_next = ARMED;
            end
            ARMED: begin
                if (accept) begin
                    unique case (op)
                        2'd1: begin
                            spi_load   = 1'b1;
                            state_next = SPI_START;
                        end
                        2'd2: begin
                            if (sel <= 6'd2) sweep_wr = 1'b1;
                            else             err_any  = 1'b1;
                        end
                        2'd3:    state_next = WAIT_MAGIC;
                        default: ;
                    endcase
                end
            end
            SPI_START: state_next = SPI_WAIT_BUSY;
            SPI_WAIT_BUSY: begin
                if (bus.i_spi_busy) begin
                    state_next = SPI_WAIT_DONE;
                end else if (timer == TIMER_LAST) begin
                    err_any    = 1'b1;
                    state_next = ARMED;
                end
            end
            SPI_WAIT_DONE: begin
                if (!bus.i_spi_busy) state_next = ARMED;
            end
            default: state_next = WAIT_MAGIC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= WAIT_MAGIC;
            timer          <= '0;
            bus.o_spi_data <= '0;
            o_sweep_diff   <= 32'd3095815;
            o_sweep_start  <= 32'd1775837915;
            o_sweep_stop   <= 32'd4291372423;
            sweep_wr_q     <= 1'b0;
            o_sweep_update <= 1'b0;
            o_err_count    <= '0;
        end else begin
            state <= state_next;
            timer <= (state == SPI_WAIT_BUSY) ? timer + 1'b1 : '0;
            if (spi_load) bus.o_spi_data <= {SPI_PREFIX, 2'b00, bus.i_word[29:0]};
            if (sweep_wr) begin
                unique case (sel)
                    6'd0:    o_sweep_diff  <= merge_half(o_sweep_diff,  bus.i_word[23], bus.i_word[15:0]);
                    6'd1:    o_sweep_start <= merge_half(o_sweep_start, bus.i_word[23], bus.i_word[15:0]);
                    default: o_sweep_stop  <= merge_half(o_sweep_stop,  bus.i_word[23], bus.i_word[15:0]);
                endcase
            end
            // Back-to-back writes merge into one pulse so the strobe never stays high.
            sweep_wr_q     <= sweep_wr;
            o_sweep_update <= sweep_wr_q && !o_sweep_update;
            if (err_any && o_err_count != 8'hFF) o_err_count <= o_err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_usb_cmd_decoder.sv
// Directed bench for usb_cmd_decoder: arming, SPI transfer, sweep writes, timeouts,
// error saturation and mid-transfer reset.
module tb_usb_cmd_decoder;
  localparam logic [31:0] MAGIC     = 32'hF00DBABE;
  localparam logic [31:0] DIFF_RST  = 32'd3095815;
  localparam logic [31:0] START_RST = 32'd1775837915;
  localparam logic [31:0] STOP_RST  = 32'd4291372423;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        armed;
  logic [31:0] sweep_diff, sweep_start, sweep_stop;
  logic        sweep_update;
  logic [7:0]  err_count;
  logic [2:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  usb_cmd_decoder_if cmd_if();

  usb_cmd_decoder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (cmd_if.slave),
    .o_armed        (armed),
    .o_sweep_diff   (sweep_diff),
    .o_sweep_start  (sweep_start),
    .o_sweep_stop   (sweep_stop),
    .o_sweep_update (sweep_update),
    .o_err_count    (err_count),
    .dbg_state      (dbg_state)
  );

  always #5 clk = ~clk;

  // Presents one word for exactly one cycle; returns at the negedge of the following cycle.
  task automatic send_word(input logic [31:0] w);
    @(negedge clk);
    cmd_if.i_word       = w;
    cmd_if.i_word_valid = 1'b1;
    @(negedge clk);
    cmd_if.i_word_valid = 1'b0;
  endtask

  task automatic test_reset;
    cmd_if.i_word       = '0;
    cmd_if.i_word_valid = 1'b0;
    cmd_if.i_spi_busy   = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (cmd_if.o_cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", cmd_if.o_cmd_ready); end
    n_vec++; if (armed !== 1'b0) begin n_err++; $display("FAIL rst_armed: got %b want 0", armed); end
    n_vec++; if (cmd_if.o_spi_start !== 1'b0) begin n_err++; $display("FAIL rst_start: got %b want 0", cmd_if.o_spi_start); end
    n_vec++; if (cmd_if.o_spi_data !== 40'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", cmd_if.o_spi_data); end
    n_vec++; if (err_count !== 8'd0) begin n_err++; $display("FAIL rst_err: got %0d want 0", err_count); end
    n_vec++; if (sweep_update !== 1'b0) begin n_err++; $display("FAIL rst_update: got %b want 0", sweep_update); end
    n_vec++; if (sweep_diff !== DIFF_RST) begin n_err++; $display("FAIL rst_diff: got %h want %h", sweep_diff, DIFF_RST); end
    n_vec++; if (sweep_start !== START_RST) begin n_err++; $display("FAIL rst_sstart: got %h want %h", sweep_start, START_RST); end
    n_vec++; if (sweep_stop !== STOP_RST) begin n_err++; $display("FAIL rst_sstop: got %h want %h", sweep_stop, STOP_RST); end
    rst_n = 1'b1;
  endtask

  task automatic test_magic;
    send_word(32'h12345678);
    n_vec++; if (armed !== 1'b0) begin n_err++; $display("FAIL magic_ignored_armed: got %b want 0", armed); end
    n_vec++; if (err_count !== 8'd0) begin n_err++; $display("FAIL magic_ignored_err: got %0d want 0", err_count); end
    send_word(MAGIC);
    n_vec++; if (armed !== 1'b1) begin n_err++; $display("FAIL magic_armed: got %b want 1", armed); end
  endtask

  task automatic test_spi;
    send_word(32'h40ABCDEF);
    n_vec++; if (cmd_if.o_spi_start !== 1'b1) begin n_err++; $display("FAIL spi_start: got %b want 1", cmd_if.o_spi_start); end
    n_vec++; if (cmd_if.o_spi_data !== 40'h0200ABCDEF) begin n_err++; $display("FAIL spi_data: got %h want 0200abcdef", cmd_if.o_spi_data); end
    n_vec++; if (cmd_if.o_cmd_ready !== 1'b0) begin n_err++; $display("FAIL spi_ready_low: got %b want 0", cmd_if.o_cmd_ready); end
    @(negedge clk);
    n_vec++; if (cmd_if.o_spi_start !== 1'b0) begin n_err++; $display("FAIL spi_start_once: got %b want 0", cmd_if.o_spi_start); end
    cmd_if.i_spi_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) begin cmd_if.i_word = 32'h00000000; cmd_if.i_word_valid = 1'b1; end
      if (i == 4) cmd_if.i_word_valid = 1'b0;
    end
    n_vec++; if (cmd_if.o_cmd_ready !== 1'b0) begin n_err++; $display("FAIL spi_busy_ready: got %b want 0", cmd_if.o_cmd_ready); end
    cmd_if.i_spi_busy = 1'b0;
    @(negedge clk);
    n_vec++; if (cmd_if.o_cmd_ready !== 1'b1) begin n_err++; $display("FAIL spi_done_ready: got %b want 1", cmd_if.o_cmd_ready); end
    n_vec++; if (err_count !== 8'd1) begin n_err++; $display("FAIL spi_drop_err: got %0d want 1", err_count); end
    n_vec++; if (cmd_if.o_spi_data !== 40'h0200ABCDEF) begin n_err++; $display("FAIL spi_data_hold: got %h want 0200abcdef", cmd_if.o_spi_data); end
  endtask

  task automatic test_sweep;
    int pulses;
    pulses = 0;
    send_word(32'h8080BEEF);
    n_vec++; if (sweep_diff !== {16'hBEEF, DIFF_RST[15:0]}) begin n_err++; $display("FAIL sweep_diff_hi: got %h want %h", sweep_diff, {16'hBEEF, DIFF_RST[15:0]}); end
    n_vec++; if (sweep_update !== 1'b0) begin n_err++; $display("FAIL sweep_upd_early: got %b want 0", sweep_update); end
    @(negedge clk);
    if (sweep_update === 1'b1) pulses++;
    @(negedge clk);
    n_vec++; if (sweep_update !== 1'b0) begin n_err++; $display("FAIL sweep_upd_width: got %b want 0", sweep_update); end
    send_word(32'h81001234);
    n_vec++; if (sweep_start !== {START_RST[31:16], 16'h1234}) begin n_err++; $display("FAIL sweep_start_lo: got %h want %h", sweep_start, {START_RST[31:16], 16'h1234}); end
    @(negedge clk);
    if (sweep_update === 1'b1) pulses++;
    n_vec++; if (pulses !== 2) begin n_err++; $display("FAIL sweep_pulses: got %0d want 2", pulses); end
    n_vec++; if (sweep_stop !== STOP_RST) begin n_err++; $display("FAIL sweep_stop_kept: got %h want %h", sweep_stop, STOP_RST); end
  endtask

  task automatic test_timeout;
    send_word(32'h40000001);
    repeat (16) @(negedge clk);
    n_vec++; if (cmd_if.o_cmd_ready !== 1'b0) begin n_err++; $display("FAIL tmo_still_wait: got %b want 0", cmd_if.o_cmd_ready); end
    n_vec++; if (err_count !== 8'd1) begin n_err++; $display("FAIL tmo_err_before: got %0d want 1", err_count); end
    @(negedge clk);
    n_vec++; if (cmd_if.o_cmd_ready !== 1'b1) begin n_err++; $display("FAIL tmo_ready: got %b want 1", cmd_if.o_cmd_ready); end
    n_vec++; if (err_count !== 8'd2) begin n_err++; $display("FAIL tmo_err: got %0d want 2", err_count); end
  endtask

  task automatic test_dual_error;
    send_word(32'h40000002);
    repeat (16) @(negedge clk);
    cmd_if.i_word       = 32'h00000000;
    cmd_if.i_word_valid = 1'b1;
    @(negedge clk);
    cmd_if.i_word_valid = 1'b0;
    n_vec++; if (err_count !== 8'd3) begin n_err++; $display("FAIL dual_err: got %0d want 3", err_count); end
    n_vec++; if (cmd_if.o_cmd_ready !== 1'b1) begin n_err++; $display("FAIL dual_ready: got %b want 1", cmd_if.o_cmd_ready); end
  endtask

  task automatic test_disarm;
    send_word(32'hC0000000);
    n_vec++; if (armed !== 1'b0) begin n_err++; $display("FAIL disarm: got %b want 0", armed); end
    send_word(32'h85000000);
    n_vec++; if (err_count !== 8'd3) begin n_err++; $display("FAIL disarm_ignore: got %0d want 3", err_count); end
    send_word(MAGIC);
    n_vec++; if (armed !== 1'b1) begin n_err++; $display("FAIL rearm: got %b want 1", armed); end
  endtask

  task automatic test_saturate_and_reset;
    @(negedge clk);
    cmd_if.i_word       = 32'h85000000;
    cmd_if.i_word_valid = 1'b1;
    repeat (300) @(negedge clk);
    cmd_if.i_word_valid = 1'b0;
    n_vec++; if (err_count !== 8'd255) begin n_err++; $display("FAIL sat_err: got %0d want 255", err_count); end
    n_vec++; if (sweep_diff !== {16'hBEEF, DIFF_RST[15:0]}) begin n_err++; $display("FAIL sat_no_write: got %h want %h", sweep_diff, {16'hBEEF, DIFF_RST[15:0]}); end
    n_vec++; if (sweep_update !== 1'b0) begin n_err++; $display("FAIL sat_no_update: got %b want 0", sweep_update); end
    send_word(32'h40ABCDEF);
    cmd_if.i_spi_busy = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++; if (armed !== 1'b0) begin n_err++; $display("FAIL mid_rst_armed: got %b want 0", armed); end
    n_vec++; if (err_count !== 8'd0) begin n_err++; $display("FAIL mid_rst_err: got %0d want 0", err_count); end
    n_vec++; if (cmd_if.o_spi_data !== 40'h0) begin n_err++; $display("FAIL mid_rst_data: got %h want 0", cmd_if.o_spi_data); end
    n_vec++; if (cmd_if.o_cmd_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready: got %b want 1", cmd_if.o_cmd_ready); end
    n_vec++; if (sweep_diff !== DIFF_RST) begin n_err++; $display("FAIL mid_rst_diff: got %h want %h", sweep_diff, DIFF_RST); end
    n_vec++; if (sweep_start !== START_RST) begin n_err++; $display("FAIL mid_rst_sstart: got %h want %h", sweep_start, START_RST); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (cmd_if.o_spi_start !== 1'b0) begin n_err++; $display("FAIL mid_rst_start: got %b want 0", cmd_if.o_spi_start); end
    end
    // Release reset and present MAGIC in the same cycle: it must be taken on the first posedge.
    rst_n               = 1'b1;
    cmd_if.i_spi_busy   = 1'b0;
    cmd_if.i_word       = MAGIC;
    cmd_if.i_word_valid = 1'b1;
    @(negedge clk);
    cmd_if.i_word_valid = 1'b0;
    n_vec++; if (armed !== 1'b1) begin n_err++; $display("FAIL first_edge_armed: got %b want 1", armed); end
  endtask

  initial begin
    test_reset();
    test_magic();
    test_spi();
    test_sweep();
    test_timeout();
    test_dual_error();
    test_disarm();
    test_saturate_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
